// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// counter sizing helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width; never below one bit so the counter is always a real vector.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit adder slice: half adder primitive and a full adder built from two of them.
// Purely combinational, zero latency, no flow control.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0, c0, c1;

    ha u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    ha u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder, one bit per clock, LSB first.
// Latency: WIDTH+1 edges from accepted start to done; one result per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             slice_s, slice_c;
    logic             last_bit;

    fa u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign last_bit = (cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;   // unused encoding recovers to IDLE
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                ra    <= a;
                rb    <= b;
                cnt   <= '0;
                carry <= 1'b0;
            end else if (state == ST_RUN) begin
                ra    <= ra >> 1;
                rb    <= rb >> 1;
                sum   <= {slice_s, sum[WIDTH-1:1]};
                carry <= slice_c;
                cnt   <= cnt + 1'b1;
                if (last_bit) cout <= slice_c;
            end
        end
    end

    // Decoded straight from the state flop, so no input reaches these combinationally.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: reset, carries, ignored start,
// mid-run reset and back-to-back operation against a + b.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; optionally pulses start with other operands in RUN cycle 3.
    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input bit poke);
        logic ok;
        a = op_a; b = op_b; start = 1'b1;
        tick();                        // E0
        start = 1'b0; a = 8'hAA; b = 8'h55;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            if ({busy, done} !== 2'b10) ok = 1'b0;
            if (poke && i == 2) begin start = 1'b1; a = 8'h77; b = 8'h11; end
            if (poke && i == 3) start = 1'b0;
            tick();
        end
        chk({tag, "_busy_window"}, ok, 1'b1);
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
        tick();
        chk({tag, "_idle_after"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [W-1:0] ra, rb, nxt_a, nxt_b;
        logic [W:0]   exp;
        logic         ok;
        int           n, last_done;

        #12;
        chk("reset_outputs", {busy, done, cout, sum}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        run_op("add_3_5", 8'h03, 8'h05, 8'h08, 1'b0, 1'b0);
        run_op("add_ff_1", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({busy, done, cout, sum} !== {3'b001, 8'h00}) ok = 1'b0;
            tick();
        end
        chk("hold_5_idle", ok, 1'b1);
        run_op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
        run_op("add_0_0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("ignore_start", 8'h21, 8'h42, 8'h63, 1'b0, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ok = 1'b0;
            tick();
        end
        chk("no_second_done", ok, 1'b1);

        // Asynchronous reset in RUN cycle 4, between edges.
        a = 8'h0F; b = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1 chk("midrun_reset_outputs", {busy, done, cout, sum}, '0);
        tick(); tick();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ok = 1'b0;
            tick();
        end
        chk("midrun_no_done", ok, 1'b1);
        run_op("add_10_20", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

        // Back-to-back with start held high; operands switch right after each accept.
        ra = W'($urandom); rb = W'($urandom);
        a = ra; b = rb; start = 1'b1;
        last_done = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("b2b_accept", busy, 1'b1);
            nxt_a = W'($urandom); nxt_b = W'($urandom);
            a = nxt_a; b = nxt_b;
            n = 1;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            chk("b2b_latency", n, W + 1);
            exp = {1'b0, ra} + {1'b0, rb};
            chk("b2b_result", {cout, sum}, exp);
            if (k > 0) chk("b2b_period", cyc - last_done, W + 2);
            last_done = cyc;
            ra = nxt_a; rb = nxt_b;
            tick();
            chk("b2b_idle", {busy, done}, 2'b00);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
